// File: rtl/mm_mont_mul_if.sv
// ---------------------------------------------------------------------------
// mm_mont_mul_if: request/result bundle for the Montgomery multiplier.
//   ce     clock enable (all multiplier registers hold while low)
//   start  launch request, accepted only in IDLE with ce high
//   a, b   operands (each expected below n)
//   n      odd modulus
//   p      result, valid while ready is high
//   ready  block idle, p holds the last result
//   err    operand-check flag (constant 0 unless MM_OPERAND_CHECK_EN)
// master: the requester driving operands; slave: the multiplier.
// ---------------------------------------------------------------------------
interface mm_mont_mul_if #(
  parameter int WIDTH = 16
) ();
  logic             ce;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] p;
  logic             ready;
  logic             err;

  modport master (
    output ce, start, a, b, n,
    input  p, ready, err
  );

  modport slave (
    input  ce, start, a, b, n,
    output p, ready, err
  );
endinterface

// File: rtl/mm_mont_mul.sv
// ---------------------------------------------------------------------------
// mm_mont_mul: bit-serial radix-2 Montgomery multiplier, p = a*b*2^-WIDTH mod n.
// One multiplier bit is consumed per enabled clock; a request takes
// 1 accept edge + WIDTH loop edges + 1 final-subtraction edge.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (wins over ce)
//   bus   mm_mont_mul_if.slave: ce, start, a, b, n in; p, ready, err out
//
// Optional build macro MM_OPERAND_CHECK_EN: when defined, err is captured at
// the accepted start as (n even) | (a >= n) | (b >= n); when undefined err
// is tied low and no comparators exist.
// ---------------------------------------------------------------------------
module mm_mont_mul #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst,
  mm_mont_mul_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOP  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_I  = CNT_W'(1);

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   n_r;
  // Accumulator stays below 2n, so two guard bits cover s + b + n.
  logic [WIDTH+1:0]   s_r;
  logic [CNT_W-1:0]   i_r;
  logic [WIDTH-1:0]   p_r;
  logic               ready_r;

  logic [WIDTH-1:0]   a_sh_s;
  logic [WIDTH+1:0]   add_s;
  logic [WIDTH+1:0]   t_s;
  logic [WIDTH+1:0]   fin_s;

  // Next-state logic for the IDLE -> LOOP -> FINAL sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = LOOP;
        end else begin
          state_s = IDLE;
        end
      end
      LOOP: begin
        if (i_r == LAST_I) begin
          state_s = FINAL;
        end else begin
          state_s = LOOP;
        end
      end
      FINAL:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, advancing only on enabled edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (bus.ce) begin
      state_r <= state_s;
    end
  end

  // One Montgomery step: add b on the current a bit, make the sum even with n, halve.
  always_comb begin
    a_sh_s = a_r >> i_r;
    add_s  = s_r + (a_sh_s[0] ? {2'b00, b_r} : {(WIDTH+2){1'b0}});
    if (add_s[0]) begin
      t_s = add_s + {2'b00, n_r};
    end else begin
      t_s = add_s;
    end
    // Final conditional subtraction brings s from [0, 2n) into [0, n).
    if (s_r >= {2'b00, n_r}) begin
      fin_s = s_r - {2'b00, n_r};
    end else begin
      fin_s = s_r;
    end
  end

`ifdef MM_OPERAND_CHECK_EN
  logic err_r;

  // Operand-check flag, captured once per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (bus.ce && (state_r == IDLE) && bus.start) begin
      err_r <= (bus.n[0] == 1'b0) | (bus.a >= bus.n) | (bus.b >= bus.n);
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  // Datapath registers: operand capture, serial accumulation, result and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      n_r     <= {WIDTH{1'b0}};
      s_r     <= {(WIDTH+2){1'b0}};
      i_r     <= {CNT_W{1'b0}};
      p_r     <= {WIDTH{1'b0}};
      ready_r <= 1'b1;
    end else if (bus.ce) begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            n_r     <= bus.n;
            s_r     <= {(WIDTH+2){1'b0}};
            i_r     <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
          end
        end
        LOOP: begin
          s_r <= t_s >> 1;
          i_r <= i_r + ONE_I;
        end
        FINAL: begin
          p_r     <= fin_s[WIDTH-1:0];
          ready_r <= 1'b1;
        end
        default: begin
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.p     = p_r;
  assign bus.ready = ready_r;

endmodule

// File: tb/tb_mm_mont_mul.sv
// ---------------------------------------------------------------------------
// tb_mm_mont_mul: self-checking bench for mm_mont_mul (WIDTH=16).
// Expected results come from an independent modular-arithmetic model and are
// queued at request time, then popped when ready rises.
// ---------------------------------------------------------------------------
module tb_mm_mont_mul;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] sb[$];

  mm_mont_mul_if #(.WIDTH(16)) bus ();

  mm_mont_mul #(
    .WIDTH(16),
    .CNT_W(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: (a*b mod n) multiplied by 2^-16 via 16 modular halvings.
  function automatic logic [15:0] mont_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] n);
    longint x;
    x = (longint'(a) * longint'(b)) % longint'(n);
    for (int k = 0; k < 16; k++) begin
      if ((x % 2) == 1) x = (x + longint'(n)) / 2;
      else              x = x / 2;
    end
    return 16'(x);
  endfunction

  function automatic logic calc_err(input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] n);
`ifdef MM_OPERAND_CHECK_EN
    return (n[0] == 1'b0) || (a >= n) || (b >= n);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] ep;
    if (sb.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      ep = sb.pop_front();
      check_eq(tag, bus.p, ep);
    end
  endtask

  // One request: optional ce stall at enabled edge 6, optional start pulses mid-loop.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n,
                        input bit chk_p, input int stall_len, input bit pulse);
    int   en;
    int   tot;
    int   held;
    logic exp_err;
    exp_err = calc_err(a, b, n);
    bus.a     = a;
    bus.b     = b;
    bus.n     = n;
    bus.ce    = 1'b1;
    bus.start = 1'b1;
    if (chk_p) sb.push_back(mont_ref(a, b, n));
    step();
    en = 1; tot = 1; held = 0;
    bus.start = 1'b0;
    check_eq("err_at_start", bus.err, exp_err);
    check_eq("busy", bus.ready, 1'b0);
    bus.a = ~a;
    bus.b = ~b;
    bus.n = ~n;
    while (!bus.ready && tot < 200) begin
      if (stall_len > 0 && en == 6 && held < stall_len) begin
        bus.ce = 1'b0;
        held++;
      end else begin
        bus.ce = 1'b1;
      end
      bus.start = (pulse && en >= 4 && en <= 6) ? 1'b1 : 1'b0;
      step();
      tot++;
      if (bus.ce) en++;
    end
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    check_eq("latency_enabled", en, 18);
    check_eq("latency_total", tot, 18 + stall_len);
    if (chk_p) pop_check("p");
    check_eq("err_hold", bus.err, exp_err);
  endtask

  // start held high: two operations with a single ready cycle between them.
  task automatic back_to_back(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n);
    int cnt;
    bus.a = a; bus.b = b; bus.n = n;
    bus.ce = 1'b1;
    bus.start = 1'b1;
    sb.push_back(mont_ref(a, b, n));
    sb.push_back(mont_ref(a, b, n));
    step();
    cnt = 1;
    while (!bus.ready && cnt < 200) begin step(); cnt++; end
    check_eq("b2b_latency1", cnt, 18);
    pop_check("b2b_p1");
    step();
    check_eq("b2b_gap_ready", bus.ready, 1'b0);
    cnt = 1;
    while (!bus.ready && cnt < 200) begin step(); cnt++; end
    bus.start = 1'b0;
    check_eq("b2b_latency2", cnt, 18);
    pop_check("b2b_p2");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ce = 1'b1; bus.start = 1'b0;
    bus.a = 16'h0000; bus.b = 16'h0000; bus.n = 16'h0001;
    repeat (3) step();
    rst = 1'b0;
    check_eq("reset_p", bus.p, 16'h0000);
    check_eq("reset_ready", bus.ready, 1'b1);
    check_eq("reset_err", bus.err, 1'b0);
    repeat (3) step();
    check_eq("idle_ready", bus.ready, 1'b1);

    // Domain identity, final subtraction, zero operand.
    run_op(16'h008D, 16'h1234, 16'h3317, 1'b1, 0, 1'b0);
    run_op(16'h008D, 16'h008D, 16'h3317, 1'b1, 0, 1'b0);
    run_op(16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op(16'h0001, 16'h1234, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op(16'h0000, 16'h2A5C, 16'h3317, 1'b1, 0, 1'b0);
    repeat (2) step();
    check_eq("p_holds_idle", bus.p, 16'h0000);

    // ce stall of 5 cycles plus ignored start pulses in LOOP.
    run_op(16'h008D, 16'h1234, 16'h3317, 1'b1, 5, 1'b1);

    // Reset on the 8th LOOP edge aborts the operation.
    bus.a = 16'h008D; bus.b = 16'h1234; bus.n = 16'h3317;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    check_eq("midop_busy", bus.ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midop_rst_ready", bus.ready, 1'b1);
    check_eq("midop_rst_p", bus.p, 16'h0000);
    check_eq("midop_rst_err", bus.err, 1'b0);
    run_op(16'h008D, 16'h0042, 16'h3317, 1'b1, 0, 1'b0);

    back_to_back(16'h1111, 16'h0777, 16'h3317);

    // Operand check cases (err expectation depends on the build macro).
    run_op(16'h008D, 16'h1234, 16'h3316, 1'b0, 0, 1'b0);
    run_op(16'h3317, 16'h1234, 16'h3317, 1'b0, 0, 1'b0);
    run_op(16'h008D, 16'h1234, 16'h3317, 1'b1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_mont_mul.md
Name: mm_mont_mul

Overview:
- Bit-serial radix-2 Montgomery multiplier for the modexp datapath.
- Computes p = a*b*R^-1 mod n, with R = 2^WIDTH.
- Sits directly downstream of mm_setup. The constant produced by mm_setup drives b with a = x, which converts operands into the Montgomery domain.
- The same block then performs every square and multiply step of the exponentiation loop.

Parameters:
- WIDTH, 16, operand/modulus width in bits; R = 2^WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when 0, all registers hold.
- start  input  1  request; sampled only when ce=1 and state IDLE.
- a  input  WIDTH  multiplicand; required a < n.
- b  input  WIDTH  multiplier; required b < n.
- n  input  WIDTH  modulus; required odd.
- p  output  WIDTH  result; valid while ready=1.
- ready  output  1  high in IDLE: block can accept start and p holds the last result.
- err  output  1  operand-check flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at a rising edge, regardless of ce): state=IDLE, p=0, ready=1, err=0, accumulator s=0, counter i=0.
- Internal registers:
  - a_r, b_r, n_r: WIDTH bits each.
  - s: WIDTH+2 bits; invariant s < 2n, so no overflow.
  - i: CNT_W bits.
- State IDLE, on start=1 and ce=1:
  - latch a_r=a, b_r=b, n_r=n;
  - s=0, i=0, ready=0;
  - go to LOOP.
- State LOOP, each ce=1 edge:
  - t = s + (a_r[i] ? b_r : 0);
  - if t[0]=1 then t = t + n_r;
  - s = t >> 1 (exact, t even);
  - i = i+1.
  - After the edge with i == WIDTH-1, go to FINAL. LOOP therefore spans exactly WIDTH enabled edges.
- State FINAL, one ce=1 edge:
  - p = (s >= n_r) ? s - n_r : s, truncated to WIDTH bits;
  - ready=1;
  - go to IDLE.
- Latency: start edge + WIDTH LOOP edges + 1 FINAL edge. ready reads high after WIDTH+2 enabled edges, i.e. 18 for WIDTH=16.
- ce=0 at any point freezes state, counter, s and outputs. Latency counts enabled edges only.
- start while not IDLE is ignored; no queuing.
- start held high continuously relaunches on the first enabled edge after ready rises. ready is high for exactly one enabled cycle between back-to-back operations.
- Inputs a/b/n may change after the start edge without affecting the operation in progress.
- Reset mid-operation aborts: IDLE, ready=1, p=0 on the next edge.
- p is updated only in FINAL and holds its value through IDLE.

Optional Feature:
- Macro: MM_OPERAND_CHECK_EN.
- Defined:
  - at the start edge, err = (n[0]==0) | (a >= n) | (b >= n);
  - the operation still runs;
  - err holds until the next accepted start or reset.
- Undefined: err is tied to 0 and no comparators are synthesised.

Test Plan:
- Reset/idle: rst=1 for 3 edges, then rst=0 -> p=0x0000, ready=1, err=0; start=0 keeps ready=1.
- Domain identity: n=0x3317, a=0x008D (R mod n), b=0x1234, start pulse -> ready low for 17 edges, high on edge 18, p=0x1234. Repeat with a=b=0x008D -> p=0x008D.
- Final subtraction / zero:
  - n=0xFFFF, a=0xFFFE, b=0xFFFE -> p=0x0001.
  - n=0xFFFF, a=0x0001, b=0x1234 -> p=0x1234.
  - a=0x0000, any b -> p=0x0000.
- ce stall and ignored start:
  - n=0x3317, a=0x008D, b=0x1234; drop ce for 5 cycles mid-LOOP -> ready high after 18 enabled edges (23 total), p=0x1234.
  - start pulses during LOOP have no effect.
- Reset mid-op and chaining:
  - assert rst at LOOP edge 8 -> next edge ready=1, p=0;
  - then a fresh start with n=0x3317, a=0x008D, b=0x0042 completes normally with p=0x0042.
- MM_OPERAND_CHECK_EN:
  - n=0x3316 (even) -> err=1 after the start edge.
  - n=0x3317, a=0x3317 -> err=1.
  - valid operands -> err=0.
  - with the macro undefined, err=0 in all three cases.
